// File: rtl/systolic_os_ctrl.sv
// systolic_os_ctrl: phase sequencer (clear, feed, flush, drain) for an output-stationary systolic array
module systolic_os_ctrl #(
  parameter int x_axis  = 3,
  parameter int y_axis  = 3,
  parameter int WIDTH_K = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [WIDTH_K-1:0]                            k_len,
  input  logic                                          stall,
  input  logic                                          abort,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic                                          reg_clear,
  output logic                                          cell_en,
  output logic                                          pipeline_en,
  output logic                                          cscan_en,
  output logic                                          feed_valid,
  output logic [WIDTH_K-1:0]                            feed_idx,
  output logic                                          out_valid,
  output logic [(x_axis > 1 ? $clog2(x_axis) : 1)-1:0]  out_col
);
  localparam int CW = x_axis > 1 ? $clog2(x_axis) : 1;
  localparam int F  = x_axis + y_axis - 2;
  localparam logic [WIDTH_K-1:0] F_LAST = WIDTH_K'(F == 0 ? 0 : F - 1);
  localparam logic [WIDTH_K-1:0] X_LAST = WIDTH_K'(x_axis - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE, ABORT} state_t;
  state_t             state, state_nxt;
  logic [WIDTH_K-1:0] cnt, cnt_nxt, k_q;
  logic               last, active;
  assign active = (state == FEED) || (state == FLUSH) || (state == DRAIN);
  assign last   = state == FEED  ? cnt == k_q - WIDTH_K'(1) :
                  state == FLUSH ? cnt == F_LAST : cnt == X_LAST;
  // next state and phase counter; counter restarts at 0 on every phase entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    state_nxt = (start && k_len != '0) ? CLEAR : IDLE;
      CLEAR:   begin state_nxt = FEED; cnt_nxt = '0; end
      DONE,
      ABORT:   begin state_nxt = IDLE; cnt_nxt = '0; end
      default: if (!stall) begin
        cnt_nxt   = last ? '0 : cnt + WIDTH_K'(1);
        state_nxt = !last ? state :
                    state == FEED  ? (F == 0 ? DRAIN : FLUSH) :
                    state == FLUSH ? DRAIN : DONE;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nxt = ABORT;
      cnt_nxt   = '0;
    end
  end
  // state, counter, captured K and the reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k_q   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= state == IDLE && start && k_len == '0;
      if (state == IDLE && start) k_q <= k_len;
    end
  end
  // stall blanks the array enables in the same cycle so a frozen wavefront is never consumed
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign reg_clear   = (state == CLEAR) || (state == ABORT);
  assign cell_en     = ((state == FEED) || (state == FLUSH)) && !stall;
  assign pipeline_en = active && !stall;
  assign cscan_en    = (state == DRAIN) && !stall;
  assign out_valid   = cscan_en;
  assign feed_valid  = (state == FEED) && !stall;
  assign feed_idx    = state == FEED ? cnt : '0;
  assign out_col     = state == DRAIN ? cnt[CW-1:0] : '0;
endmodule
